// File: rtl/multi_ch_frame_tx_pkg.sv
// Shared types and helpers for the multi-channel serial frame transmitter.
package multi_ch_frame_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam int PARITY_BITS = 2;
    localparam int STOP_BITS   = 1;

    // Total line bits per frame: markers + words, then parity and stop.
    function automatic int frame_bits(input int n_ch, input int mark_bits, input int data_w);
        return n_ch * (mark_bits + data_w) + PARITY_BITS + STOP_BITS;
    endfunction

endpackage

// File: rtl/multi_ch_frame_tx_if.sv
// Frame input handshake: valid/ready plus the concatenated channel words.
interface multi_ch_frame_tx_if #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 2
);
    logic                     frame_valid;
    logic                     frame_ready;
    logic [N_CH*DATA_W-1:0]   tx_data;

    modport master (output frame_valid, output tx_data, input frame_ready);
    modport slave  (input frame_valid, input tx_data, output frame_ready);
endinterface

// File: rtl/multi_ch_frame_tx_baud_tick_gen.sv
// Bit-period divider (baud_tick_gen): one-cycle tick every DIV enabled cycles.
module multi_ch_frame_tx_baud_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk_1M,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tick
);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == LAST);

    // Divider counter; restarts on a new frame so bit 0 gets a full period.
    always_ff @(posedge clk_1M) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/multi_ch_frame_tx.sv
// Multi-channel serial frame transmitter.
// Optional feature macro: FRAME_TX_PARITY_EN (real even parity in both
// parity bits); when undefined the parity bits are constant 0.
module multi_ch_frame_tx
    import multi_ch_frame_tx_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int N_CH      = 2,
    parameter int MARK_BITS = 2,
    parameter int DIV       = 1
) (
    input  logic                 clk_1M,
    input  logic                 rst,
    multi_ch_frame_tx_if.slave   s_if,
    output logic                 tx,
    output logic                 busy
);
    localparam int            FB   = frame_bits(N_CH, MARK_BITS, DATA_W);
    localparam int            SLOT = MARK_BITS + DATA_W;
    localparam int            BW   = (FB > 1) ? $clog2(FB) : 1;
    localparam logic [BW-1:0] LAST_SEND_BIT = BW'(FB - 2);

    if (DATA_W < 1 || N_CH < 1 || MARK_BITS < 1 || DIV < 1) begin : g_bad_params
        $fatal(1, "multi_ch_frame_tx: DATA_W, N_CH, MARK_BITS and DIV must all be >= 1");
    end

    state_t               r_state;
    state_t               w_state_next;
    logic [FB-1:0]        r_shift;
    logic [BW-1:0]        r_bit;
    logic                 w_accept;
    logic                 w_tick;
    logic                 w_par;
    logic [N_CH*SLOT-1:0] w_body;
    logic [FB-1:0]        w_frame;

    assign s_if.frame_ready = (r_state == IDLE) && !rst;
    assign w_accept         = s_if.frame_valid && s_if.frame_ready;
    assign busy             = (r_state != IDLE);
    // Line bit is always the LSB of the shift register, so tx is a flop output.
    assign tx               = r_shift[0];

    // Each channel slot: marker zeros first on the line, then the word LSB first.
    genvar gi;
    for (gi = 0; gi < N_CH; gi++) begin : g_slot
        assign w_body[gi*SLOT +: SLOT] = {s_if.tx_data[gi*DATA_W +: DATA_W], {MARK_BITS{1'b0}}};
    end

`ifdef FRAME_TX_PARITY_EN
    assign w_par = ^s_if.tx_data;
`else
    assign w_par = 1'b0;
`endif

    assign w_frame = {1'b1, w_par, w_par, w_body};

    multi_ch_frame_tx_baud_tick_gen #(.DIV(DIV)) u_baud_tick_gen (
        .clk_1M  (clk_1M),
        .rst     (rst),
        .i_clear (w_accept),
        .i_en    (busy),
        .o_tick  (w_tick)
    );

    // State register.
    always_ff @(posedge clk_1M) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic: SEND covers marker/data/parity, STOP the final bit.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = SEND;
            SEND:    if (w_tick && (r_bit == LAST_SEND_BIT)) w_state_next = STOP;
            STOP:    if (w_tick) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Frame shift register (ones shifted in keep the line idle high) and bit counter.
    always_ff @(posedge clk_1M) begin
        if (rst) begin
            r_shift <= '1;
            r_bit   <= '0;
        end else if (w_accept) begin
            r_shift <= w_frame;
            r_bit   <= '0;
        end else if (w_tick) begin
            r_shift <= {1'b1, r_shift[FB-1:1]};
            if (r_state == SEND) r_bit <= r_bit + 1'b1;
        end
    end
endmodule

// File: tb/tb_multi_ch_frame_tx.sv
// Self-checking bench: three configurations of multi_ch_frame_tx against a
// line-format reference model built from the frame layout rules.
module tb_multi_ch_frame_tx;
    localparam int P_DW [3] = '{8, 8, 6};
    localparam int P_NCH[3] = '{2, 2, 4};
    localparam int P_MK [3] = '{2, 2, 1};
    localparam int P_DIV[3] = '{1, 4, 2};

    logic        clk = 1'b0;
    logic        rst;
    logic        valid  [3];
    logic [63:0] data   [3];
    logic        tx_o   [3];
    logic        busy_o [3];
    logic        ready_o[3];

    int n_checks = 0;
    int n_errors = 0;
    bit exp_bits[64];
    int exp_len;

    always #5 clk = ~clk;

    multi_ch_frame_tx_if #(.DATA_W(8), .N_CH(2)) if0 ();
    multi_ch_frame_tx_if #(.DATA_W(8), .N_CH(2)) if1 ();
    multi_ch_frame_tx_if #(.DATA_W(6), .N_CH(4)) if2 ();

    assign if0.frame_valid = valid[0];
    assign if0.tx_data     = data[0][15:0];
    assign ready_o[0]      = if0.frame_ready;
    assign if1.frame_valid = valid[1];
    assign if1.tx_data     = data[1][15:0];
    assign ready_o[1]      = if1.frame_ready;
    assign if2.frame_valid = valid[2];
    assign if2.tx_data     = data[2][23:0];
    assign ready_o[2]      = if2.frame_ready;

    multi_ch_frame_tx #(.DATA_W(8), .N_CH(2), .MARK_BITS(2), .DIV(1)) u_dut0 (
        .clk_1M(clk), .rst(rst), .s_if(if0), .tx(tx_o[0]), .busy(busy_o[0]));
    multi_ch_frame_tx #(.DATA_W(8), .N_CH(2), .MARK_BITS(2), .DIV(4)) u_dut1 (
        .clk_1M(clk), .rst(rst), .s_if(if1), .tx(tx_o[1]), .busy(busy_o[1]));
    multi_ch_frame_tx #(.DATA_W(6), .N_CH(4), .MARK_BITS(1), .DIV(2)) u_dut2 (
        .clk_1M(clk), .rst(rst), .s_if(if2), .tx(tx_o[2]), .busy(busy_o[2]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] word_mask(input int k);
        return (64'd1 << (P_NCH[k] * P_DW[k])) - 64'd1;
    endfunction

    // Reference line image: per channel MARK zeros then word LSB first,
    // two parity bits, one stop bit.
    function automatic void build_exp(input int k, input logic [63:0] d);
        int p = 0;
        bit par = 1'b0;
        for (int c = 0; c < P_NCH[k]; c++) begin
            for (int m = 0; m < P_MK[k]; m++) exp_bits[p++] = 1'b0;
            for (int b = 0; b < P_DW[k]; b++) begin
                exp_bits[p++] = d[c*P_DW[k] + b];
                par ^= d[c*P_DW[k] + b];
            end
        end
`ifdef FRAME_TX_PARITY_EN
        exp_bits[p] = par;
        exp_bits[p+1] = par;
`else
        exp_bits[p] = 1'b0;
        exp_bits[p+1] = 1'b0;
`endif
        p += 2;
        exp_bits[p++] = 1'b1;
        exp_len = p;
    endfunction

    // Send one frame on instance k and check every cycle of it plus the idle cycle after.
    task automatic run_frame(input int k, input logic [63:0] d, input bit hold, input bit scramble);
        logic [63:0] dm;
        dm = d & word_mask(k);
        build_exp(k, dm);
        @(negedge clk);
        check($sformatf("k%0d ready_before_frame", k), ready_o[k], 1);
        valid[k] = 1'b1;
        data[k]  = dm;
        for (int i = 0; i < exp_len; i++) begin
            for (int j = 0; j < P_DIV[k]; j++) begin
                @(posedge clk);
                #1;
                if (i == 0 && j == 0) begin
                    if (!hold) valid[k] = 1'b0;
                    if (scramble) data[k] = ~dm;
                end
                check($sformatf("k%0d data=%0h tx bit%0d cyc%0d", k, dm, i, j), tx_o[k], exp_bits[i]);
                check($sformatf("k%0d busy bit%0d cyc%0d", k, i, j), busy_o[k], 1);
                check($sformatf("k%0d ready_in_frame bit%0d", k, i), ready_o[k], 0);
            end
        end
        @(posedge clk);
        #1;
        check($sformatf("k%0d idle tx", k), tx_o[k], 1);
        check($sformatf("k%0d idle busy", k), busy_o[k], 0);
        check($sformatf("k%0d idle ready", k), ready_o[k], 1);
        $display("frame k%0d data=%0h bits=%0d div=%0d hold=%0d scramble=%0d checks=%0d errors=%0d",
                 k, dm, exp_len, P_DIV[k], hold, scramble, n_checks, n_errors);
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            valid[k] = 1'b0;
            data[k]  = '0;
        end

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("k%0d reset tx", k), tx_o[k], 1);
            check($sformatf("k%0d reset busy", k), busy_o[k], 0);
            check($sformatf("k%0d reset ready", k), ready_o[k], 0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) check($sformatf("k%0d ready after reset", k), ready_o[k], 1);

        // Default format, parity cases.
        run_frame(0, 64'h3CA5, 0, 0);
        run_frame(0, 64'h0001, 0, 0);

        // DIV=4: held bits, 92-cycle busy, data change after accept ignored.
        run_frame(1, 64'hFF00, 0, 1);

        // frame_valid held high: back-to-back frames with a single idle cycle.
        run_frame(0, 64'h1234, 1, 0);
        run_frame(0, 64'hBEEF, 1, 0);
        run_frame(0, 64'h00FF, 1, 0);
        valid[0] = 1'b0;

        // Reset in the middle of a frame (at bit 12).
        build_exp(0, 64'h5A3C);
        @(negedge clk);
        valid[0] = 1'b1;
        data[0]  = 64'h5A3C;
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("rstmid tx bit12", tx_o[0], exp_bits[12]);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid tx", tx_o[0], 1);
        check("rstmid busy", busy_o[0], 0);
        check("rstmid ready during rst", ready_o[0], 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid ready after rst", ready_o[0], 1);
        $display("reset mid-frame k0 checks=%0d errors=%0d", n_checks, n_errors);
        run_frame(0, 64'h5A3C, 0, 0);

        // Wide config: marker positions 0/7/14/21 come from the model.
        run_frame(2, 64'h00AB_CDEF, 0, 0);

        // Randomised frames on all configurations.
        for (int n = 0; n < 6; n++) begin
            for (int k = 0; k < 3; k++) begin
                run_frame(k, {$urandom, $urandom}, 0, n[0]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
